// File: rtl/nn_pkg.sv
// Types and default dimensions shared by the layer modules and the classifier head.
// No logic, so no latency or backpressure of its own.
package nn_pkg;

  // Defaults match the M=10, T=16 output layer.
  localparam int NN_M = 10;
  localparam int NN_T = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REPORT  = 2'd1
  } state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Running-argmax step: chooses between the held maximum and the incoming element.
// Purely combinational, so it adds no latency and has no backpressure.
module argmax_cmp #(
  parameter int T  = 16,
  parameter int IW = 4
) (
  input  logic signed [T-1:0]  cur_max,
  input  logic        [IW-1:0] cur_idx,
  input  logic signed [T-1:0]  data_in,
  input  logic        [IW-1:0] cnt,
  output logic signed [T-1:0]  next_max,
  output logic        [IW-1:0] next_idx
);

  logic take;

  // The first element always loads, so a vector of only negative values still works.
  // Strict greater-than means a tie keeps the lower index.
  assign take     = (cnt == '0) || (data_in > cur_max);
  assign next_max = take ? data_in : cur_max;
  assign next_idx = take ? cnt     : cur_idx;

endmodule

// File: rtl/layer_argmax_sink.sv
// Classifier head: takes M signed elements per vector and reports (argmax index, max value).
// Result valid the cycle after the M-th accept; s_ready stays low until the result handshakes.
module layer_argmax_sink
  import nn_pkg::*;
#(
  parameter  int M  = NN_M,
  parameter  int T  = NN_T,
  localparam int IW = $clog2(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [IW-1:0]       class_out,
  output logic signed [T-1:0] max_out
);

  state_e              state_q, state_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic signed [T-1:0] max_q, max_d;
  logic                m_valid_q, m_valid_d;
  logic [IW-1:0]       class_q, class_d;
  logic signed [T-1:0] max_out_q, max_out_d;

  logic                acc;
  logic                last;
  logic signed [T-1:0] next_max;
  logic [IW-1:0]       next_idx;

  assign s_ready = (state_q == COLLECT);
  assign acc     = s_valid & s_ready;
  assign last    = (cnt_q == IW'(M - 1));

  argmax_cmp #(
    .T  (T),
    .IW (IW)
  ) u_cmp (
    .cur_max  (max_q),
    .cur_idx  (idx_q),
    .data_in  (data_in),
    .cnt      (cnt_q),
    .next_max (next_max),
    .next_idx (next_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    max_d     = max_q;
    m_valid_d = m_valid_q;
    class_d   = class_q;
    max_out_d = max_out_q;

    case (state_q)
      COLLECT: begin
        if (acc) begin
          max_d = next_max;
          idx_d = next_idx;
          if (last) begin
            // Load the outputs from the comparator so the M-th element is included.
            cnt_d     = '0;
            state_d   = REPORT;
            m_valid_d = 1'b1;
            class_d   = next_idx;
            max_out_d = next_max;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REPORT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = COLLECT;
        end
      end
      default: begin
        state_d   = COLLECT;
        cnt_d     = '0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      m_valid_q <= 1'b0;
      class_q   <= '0;
      max_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      m_valid_q <= m_valid_d;
      class_q   <= class_d;
      max_out_q <= max_out_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign class_out = class_q;
  assign max_out   = max_out_q;

endmodule
